// File: rtl/cskip_seq_adder.sv
`default_nettype none
// ============================================================================
// Module  : cskip_seq_adder
// Brief   : Wide adder built from one 4-bit carry-skip slice, one nibble per
//           cycle, LSB first, behind valid/ready handshakes. Optional macro
//           CSKIP_OVF_EN adds the signed-overflow output ovf.
// Revision: 1.0 - initial release
// ============================================================================
module cskip_seq_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic [NIBBLES-1:0]     skip
`ifdef CSKIP_OVF_EN
    ,
    output logic                   ovf
`endif
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NIBBLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_sum;
    logic [NIBBLES-1:0] r_skip;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_p;
    logic [3:0]       w_g;
    logic [4:0]       w_c;
    logic [3:0]       w_s;
    logic             w_grp_p;
    logic             w_carry_next;
    logic             w_accept;

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_a_nib  = r_a[4*r_idx +: 4];
    assign w_b_nib  = r_b[4*r_idx +: 4];
    assign w_p      = w_a_nib ^ w_b_nib;
    assign w_g      = w_a_nib & w_b_nib;
    assign w_grp_p  = &w_p;

    always_comb begin
        w_c    = '0;
        w_s    = '0;
        w_c[0] = r_carry;
        for (int j = 0; j < 4; j++) begin
            w_s[j]   = w_p[j] ^ w_c[j];
            w_c[j+1] = w_g[j] | (w_p[j] & w_c[j]);
        end
    end

    // With full group propagate the incoming carry bypasses the ripple chain;
    // both paths yield the same value, only the skip flag differs.
    assign w_carry_next = w_grp_p ? r_carry : w_c[4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_skip  <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_skip  <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[4*r_idx +: 4] <= w_s;
                    r_skip[r_idx]       <= w_grp_p;
                    r_carry             <= w_carry_next;
                    if (r_idx == c_LAST_IDX) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef CSKIP_OVF_EN
    logic r_ovf;

    // Top nibble: carry into the MSB is w_c[3], carry out of it is w_c[4].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if ((r_state == S_RUN) && (r_idx == c_LAST_IDX)) begin
            r_ovf <= w_c[3] ^ w_c[4];
        end
    end

    assign ovf = r_ovf;
`endif

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_carry;
    assign skip      = r_skip;

endmodule
`default_nettype wire

// File: tb/tb_cskip_seq_adder.sv
`default_nettype none
// Directed testbench for cskip_seq_adder (NIBBLES = 4).
module tb_cskip_seq_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic [3:0]  skip;
`ifdef CSKIP_OVF_EN
    logic        ovf;
`endif

    int n_checks;
    int n_fail;
    int lat;

    cskip_seq_adder #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .skip      (skip)
`ifdef CSKIP_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accept one request, then wait (bounded) for out_valid; lat = edges after accept.
    task automatic run_req(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc);
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if ({cout, sum, skip} !== 21'h0) begin n_fail++; $display("FAIL reset_outputs: got cout=%b sum=%h skip=%h want 0", cout, sum, skip); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_all_skip();
        run_req(16'h00FF, 16'hFF00, 1'b1);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL skip_latency: got %0d want 4", lat); end
        n_checks++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL skip_sum: got %h want 0000", sum); end
        n_checks++; if (cout !== 1'b1) begin n_fail++; $display("FAIL skip_cout: got %b want 1", cout); end
        n_checks++; if (skip !== 4'hF) begin n_fail++; $display("FAIL skip_flags: got %h want F", skip); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL done_in_ready: got %b want 0", in_ready); end
        release_result();
        n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL done_release: got ov/ir=%b want 01", {out_valid, in_ready}); end
    endtask

    task automatic test_carry_chain();
        run_req(16'hFFFF, 16'h0001, 1'b0);
        n_checks++; if ({cout, sum} !== 17'h10000) begin n_fail++; $display("FAIL chain_result: got cout=%b sum=%h want 1/0000", cout, sum); end
        n_checks++; if (skip !== 4'hE) begin n_fail++; $display("FAIL chain_skip: got %h want E", skip); end
        release_result();
        run_req(16'h1234, 16'h4321, 1'b0);
        n_checks++; if ({cout, sum} !== 17'h05555) begin n_fail++; $display("FAIL mixed_result: got cout=%b sum=%h want 0/5555", cout, sum); end
        n_checks++; if (skip !== 4'h0) begin n_fail++; $display("FAIL mixed_skip: got %h want 0", skip); end
        release_result();
    endtask

    task automatic test_backpressure();
        run_req(16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        a = 16'h0005; b = 16'h0003; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++; if (sum !== 16'h3333 || out_valid !== 1'b1 || in_ready !== 1'b0)
                begin n_fail++; $display("FAIL bp_hold%0d: got sum=%h ov=%b ir=%b want 3333/1/0", i, sum, out_valid, in_ready); end
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle: got in_ready=%b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_accept: got in_ready=%b want 0", in_ready); end
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        n_checks++; if (lat !== 4 || {cout, sum} !== 17'h00008) begin n_fail++; $display("FAIL bp_pending: got lat=%0d sum=%h want 4/0008", lat, sum); end
        release_result();
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b0;
        #1;
        n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL mrst_flags: got ov/ir=%b want 01", {out_valid, in_ready}); end
        n_checks++; if ({cout, sum, skip} !== 21'h0) begin n_fail++; $display("FAIL mrst_outputs: got cout=%b sum=%h skip=%h want 0", cout, sum, skip); end
        @(negedge clk); rst_n = 1'b1;
        run_req(16'h0F0F, 16'h0101, 1'b0);
        n_checks++; if ({cout, sum} !== 17'h01010) begin n_fail++; $display("FAIL mrst_next: got cout=%b sum=%h want 0/1010", cout, sum); end
        n_checks++; if (skip !== 4'h0) begin n_fail++; $display("FAIL mrst_skip: got %h want 0", skip); end
        release_result();
    endtask

`ifdef CSKIP_OVF_EN
    task automatic test_ovf();
        run_req(16'h7FFF, 16'h0001, 1'b0);
        n_checks++; if ({ovf, cout, sum} !== 18'h28000) begin n_fail++; $display("FAIL ovf_pos: got ovf=%b cout=%b sum=%h want 1/0/8000", ovf, cout, sum); end
        release_result();
        run_req(16'hFFFF, 16'h0001, 1'b0);
        n_checks++; if ({ovf, cout, sum} !== 18'h10000) begin n_fail++; $display("FAIL ovf_neg: got ovf=%b cout=%b sum=%h want 0/1/0000", ovf, cout, sum); end
        release_result();
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_all_skip();
        test_carry_chain();
        test_backpressure();
        test_mid_reset();
`ifdef CSKIP_OVF_EN
        test_ovf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cskip_seq_adder.md
# cskip_seq_adder

Multi-cycle wide adder that streams operand nibbles through one internal 4-bit carry-skip slice, one nibble per cycle, LSB first, registering the inter-nibble carry. Sits upstream of and wraps the 4-bit carry-skip stage. It turns a wide add request into a sequence of slice operations behind a valid/ready handshake. Used where a full-width combinational carry-skip chain is too large.

## Interface
- NIBBLES, 4: number of 4-bit slices. Operand width W = 4*NIBBLES. Legal range 1..16.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request. High only in IDLE.
- a  in  W  operand A, sampled on accept.
- b  in  W  operand B, sampled on accept.
- cin  in  1  carry-in, sampled on accept.
- out_valid  out  1  result valid. High only in DONE.
- out_ready  in  1  consumer accepts the result.
- sum  out  W  result.
- cout  out  1  final carry-out.
- skip  out  NIBBLES  bit i = 1 if nibble i took the skip path (group propagate = 1).
- ovf  out  1  signed overflow. Present only with CSKIP_OVF_EN.

## Operation
- FSM has three states, with these transitions:
  - IDLE -> RUN on accept, where accept = in_valid & in_ready. On accept, latch a, b and cin. Set idx = 0 and carry = cin. Clear sum and skip.
  - RUN: each cycle processes nibble idx.
    - p[j] = a[j]^b[j] and g[j] = a[j]&b[j] for the 4 bits.
    - Ripple sum bits using carry.
    - Group propagate P = p0&p1&p2&p3.
    - If P = 1: carry_next = carry (skip path), and skip[idx] is set.
    - Otherwise: carry_next = ripple carry-out of bit 3.
    - sum[4*idx+3:4*idx] is written and carry <= carry_next.
    - RUN -> DONE when idx = NIBBLES-1; otherwise idx increments.
  - DONE: out_valid = 1; sum, cout = carry, skip and ovf are held stable. DONE -> IDLE when out_ready = 1.
- in_ready = (state == IDLE), a combinational decode of the state register.
- No new request is accepted while in RUN or DONE. in_valid is ignored there.
- Arithmetic is unsigned modulo 2^W, with the carry in cout. The result must equal {cout,sum} = a + b + cin for all inputs.
- Skip and ripple paths must produce identical carries. The skip path only affects which flags are recorded.
- A mid-operation reset (rst_n low in RUN or DONE) abandons the operation immediately. There is no partial result and no out_valid pulse.

## Timing
- Reset values:
  - state = IDLE, so in_ready = 1.
  - out_valid = 0.
  - sum = 0, cout = 0, skip = 0, ovf = 0.
  - idx = 0, carry = 0.
- Latency: accept at edge k, then nibble i is processed in the cycle after edge k+i. out_valid rises after edge k+NIBBLES.
- Result is held for as long as out_ready is low. Outputs must not change while out_valid = 1.
- When out_ready is high in the first DONE cycle, out_valid falls and in_ready rises after the next edge.
- Minimum request spacing is NIBBLES+2 cycles: 1 accept, NIBBLES RUN, 1 DONE.
- NIBBLES = 1: RUN lasts exactly one cycle.
- sum, cout, skip and ovf are registered outputs. There is no combinational path from inputs to outputs.

## Configuration
- CSKIP_OVF_EN defined:
  - ovf port exists.
  - In the last RUN cycle, ovf <= carry into bit W-1 XOR carry out of bit W-1.
  - ovf is held in DONE and cleared on accept.
- CSKIP_OVF_EN undefined: ovf port and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use NIBBLES = 4.
- a=0x00FF, b=0xFF00, cin=1 -> sum=0x0000, cout=1, skip=0xF. out_valid asserts 4 cycles after accept.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, skip=0xE.
- a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, skip=0x0.
- Backpressure: after the result of 0x1111+0x2222 (=0x3333), hold out_ready=0 for 3 cycles while in_valid=1 with a new request.
  - Required: sum stays 0x3333, out_valid stays 1, in_ready stays 0 and no accept occurs.
  - After out_ready=1, the block returns to IDLE and the pending request is accepted.
- Reset mid-operation: pulse rst_n low during RUN nibble 2.
  - Required: out_valid=0, in_ready=1 and sum=0 immediately.
  - A following request 0x0F0F+0x0101 yields 0x1010, cout=0.
- With CSKIP_OVF_EN: 0x7FFF+0x0001 -> sum=0x8000, ovf=1. Then 0xFFFF+0x0001 -> ovf=0, cout=1.
